// File: rtl/aes_pkg.sv
// Shared types and constants for the AES-128 inverse key sequencer.
package aes_pkg;

  localparam int ROUND_W = 4;

  typedef logic [ROUND_W-1:0] round_t;
  typedef logic [127:0]       key_t;

  typedef enum logic [1:0] {
    IDLE,
    FWD,
    EMIT
  } state_t;

  // Round constants, top byte of the word; index = round of the key being consumed.
  localparam logic [7:0] RCON [10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Full RCON word; indices outside 0..9 (including the wrap of 0-1) give zero.
  function automatic logic [31:0] rcon_word(input round_t idx);
    if (idx < round_t'(10)) begin
      return {RCON[idx], 24'h0};
    end
    return 32'h0;
  endfunction

endpackage

// File: rtl/inv_key_sched_if.sv
// Key request / round-key stream bundle between key register, sequencer and round datapath.
interface inv_key_sched_if;

  logic               start;
  logic               key_is_last;
  aes_pkg::key_t      key_in;
  aes_pkg::key_t      rkey;
  aes_pkg::round_t    rkey_round;
  logic               rkey_valid;
  logic               rkey_ready;
  logic               busy;
  logic               done;

  // Requester / consumer side.
  modport master (
    output start, key_is_last, key_in, rkey_ready,
    input  rkey, rkey_round, rkey_valid, busy, done
  );

  // Sequencer side.
  modport slave (
    input  start, key_is_last, key_in, rkey_ready,
    output rkey, rkey_round, rkey_valid, busy, done
  );

endinterface

// File: rtl/inv_key_sched_sub_word.sv
// Combinational AES SubWord: four independent byte S-box lookups.
module sub_word (
  input  logic [31:0] w_in,
  output logic [31:0] w_out
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // One lookup per byte lane.
  for (genvar i = 0; i < 4; i++) begin : g_byte
    assign w_out[8*i +: 8] = SBOX[w_in[8*i +: 8]];
  end

endmodule

// File: rtl/inv_key_sched.sv
// AES-128 decryption round-key sequencer: emits round keys 10..0 on a valid/ready stream,
// optionally running the forward expansion first when given the cipher key.
module inv_key_sched
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = 10
) (
  input logic            clk,
  input logic            rst,
  inv_key_sched_if.slave bus
);

  localparam round_t LAST_ROUND = round_t'(NUM_ROUNDS);

  state_t      state_q, state_d;
  key_t        key_q,   key_d;
  round_t      round_q, round_d;
  logic        valid_q, valid_d;
  logic        busy_q,  busy_d;
  logic        done_q,  done_d;

  logic [31:0] k0, k1, k2, k3;
  logic [31:0] n0, n1, n2, n3;
  logic [31:0] p0, p1, p2, p3;
  logic [31:0] sw_sel, sw_in, sw_out, rcon_w;
  round_t      rcon_idx;
  logic        accept;

  assign k0 = key_q[127:96];
  assign k1 = key_q[95:64];
  assign k2 = key_q[63:32];
  assign k3 = key_q[31:0];

  // Inverse step: the last three words of the previous key fall out of simple XORs.
  assign p3 = k3 ^ k2;
  assign p2 = k2 ^ k1;
  assign p1 = k1 ^ k0;

  // The single S-box word is shared: forward uses k[3], inverse uses the recovered p[3].
  assign sw_sel   = (state_q == FWD) ? k3 : p3;
  assign sw_in    = {sw_sel[23:0], sw_sel[31:24]};
  assign rcon_idx = (state_q == FWD) ? round_q : round_q - round_t'(1);
  assign rcon_w   = rcon_word(rcon_idx);

  sub_word u_sub_word (
    .w_in  (sw_in),
    .w_out (sw_out)
  );

  assign n0 = k0 ^ sw_out ^ rcon_w;
  assign n1 = n0 ^ k1;
  assign n2 = n1 ^ k2;
  assign n3 = n2 ^ k3;
  assign p0 = k0 ^ sw_out ^ rcon_w;

  assign accept = valid_q && bus.rkey_ready;

  // Next-state and next-output computation for the sequencer.
  always_comb begin
    // NOTE: every signal gets a default here so no path leaves one unassigned and infers a latch.
    state_d = state_q;
    key_d   = key_q;
    round_d = round_q;
    valid_d = valid_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          key_d = bus.key_in;
          if (bus.key_is_last) begin
            round_d = LAST_ROUND;
            valid_d = 1'b1;
            state_d = EMIT;
          end else begin
            round_d = '0;
            state_d = FWD;
          end
        end
      end
      FWD: begin
        key_d   = {n0, n1, n2, n3};
        round_d = round_q + round_t'(1);
        if (round_q == LAST_ROUND - round_t'(1)) begin
          valid_d = 1'b1;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (accept) begin
          if (round_q != '0) begin
            key_d   = {p0, p1, p2, p3};
            round_d = round_q - round_t'(1);
          end else begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q <= IDLE;
      key_q   <= '0;
      round_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.rkey       = key_q;
  assign bus.rkey_round = round_q;
  assign bus.rkey_valid = valid_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule
